// File: rtl/rf_context_engine.sv
`default_nettype none
// ============================================================================
// Module  : rf_context_engine
// Brief   : Moves registers 1..31 between the register file and a memory
//           context area, one register at a time.
// Rev     : 1.0  initial release
// ============================================================================
module rf_context_engine #(
    parameter int BASE_ADDR = 0,
    parameter int AW        = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    output logic          busy,
    output logic          done,
    output logic [4:0]    rf_ra1,
    input  logic [31:0]   rf_rd1,
    output logic          rf_we,
    output logic [4:0]    rf_wa,
    output logic [31:0]   rf_wd,
    output logic [31:0]   r30_out,
    output logic          r30_valid,
    output logic          mem_req,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S_RD   = 3'd1,
        S_REQ  = 3'd2,
        R_REQ  = 3'd3,
        R_WAIT = 3'd4,
        R_WR   = 3'd5,
        FIN    = 3'd6
    } state_t;

    localparam logic [4:0] C_FIRST_IDX = 5'd1;
    localparam logic [4:0] C_LAST_IDX  = 5'd31;
    localparam logic [4:0] C_R30_IDX   = 5'd30;

    state_t        state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   rf_wd_q, rf_wd_d;
    logic [31:0]   r30_out_q, r30_out_d;
    logic [AW-1:0] w_slot_addr;

    // Slot address wraps naturally at AW bits.
    assign w_slot_addr = AW'(BASE_ADDR) + AW'(idx_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mem_wdata_d = mem_wdata_q;
        rf_wd_d     = rf_wd_q;
        r30_out_d   = r30_out_q;
        busy        = (state_q != IDLE);
        done        = 1'b0;
        rf_ra1      = 5'd0;
        rf_we       = 1'b0;
        rf_wa       = 5'd0;
        r30_valid   = 1'b0;
        mem_req     = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = C_FIRST_IDX;
                    state_d = mode ? R_REQ : S_RD;
                end
            end
            S_RD: begin
                rf_ra1      = idx_q;
                mem_wdata_d = rf_rd1;
                state_d     = S_REQ;
            end
            S_REQ: begin
                mem_req  = 1'b1;
                mem_wr   = 1'b1;
                mem_addr = w_slot_addr;
                if (mem_gnt) begin
                    if (idx_q == C_LAST_IDX) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = S_RD;
                    end
                end
            end
            R_REQ: begin
                mem_req  = 1'b1;
                mem_addr = w_slot_addr;
                if (mem_gnt) begin
                    state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (mem_rvalid) begin
                    if (idx_q == C_R30_IDX) begin
                        r30_out_d = mem_rdata;
                    end else begin
                        rf_wd_d = mem_rdata;
                    end
                    state_d = R_WR;
                end
            end
            R_WR: begin
                // r30 goes through the register file's dedicated input instead.
                if (idx_q == C_R30_IDX) begin
                    r30_valid = 1'b1;
                end else begin
                    rf_we = 1'b1;
                    rf_wa = idx_q;
                end
                if (idx_q == C_LAST_IDX) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = R_REQ;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= C_FIRST_IDX;
            mem_wdata_q <= 32'd0;
            rf_wd_q     <= 32'd0;
            r30_out_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mem_wdata_q <= mem_wdata_d;
            rf_wd_q     <= rf_wd_d;
            r30_out_q   <= r30_out_d;
        end
    end

    assign mem_wdata = mem_wdata_q;
    assign rf_wd     = rf_wd_q;
    assign r30_out   = r30_out_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_context_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_rf_context_engine
// Brief   : Table-driven save/restore runs against a memory/RF reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_rf_context_engine;

    localparam int AW     = 10;
    localparam int BASE_A = 256;
    localparam int BASE_B = 1020;

    typedef struct {
        bit mode;
        int gmax;
        int rvd;
        bit poke;
        int pat;
        int exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic mode = 1'b0;
    logic mem_gnt = 1'b0;
    logic mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    logic          busy_a, done_a, rf_we_a, r30_valid_a, mem_req_a, mem_wr_a;
    logic [4:0]    rf_ra1_a, rf_wa_a;
    logic [31:0]   rf_rd1_a, rf_wd_a, r30_out_a, mem_wdata_a;
    logic [AW-1:0] mem_addr_a;
    logic          busy_b, done_b, rf_we_b, r30_valid_b, mem_req_b, mem_wr_b;
    logic [4:0]    rf_ra1_b, rf_wa_b;
    logic [31:0]   rf_rd1_b, rf_wd_b, r30_out_b, mem_wdata_b;
    logic [AW-1:0] mem_addr_b;

    logic [31:0]   rf_m  [32];
    logic [31:0]   mem_m [1024];
    logic [AW-1:0] b_slot[32];

    int checks = 0;
    int errors = 0;

    assign rf_rd1_a = rf_m[rf_ra1_a];
    assign rf_rd1_b = rf_m[rf_ra1_b];

    always #5 clk = ~clk;

    rf_context_engine #(.BASE_ADDR(BASE_A), .AW(AW)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .busy(busy_a), .done(done_a), .rf_ra1(rf_ra1_a), .rf_rd1(rf_rd1_a),
        .rf_we(rf_we_a), .rf_wa(rf_wa_a), .rf_wd(rf_wd_a),
        .r30_out(r30_out_a), .r30_valid(r30_valid_a),
        .mem_req(mem_req_a), .mem_wr(mem_wr_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    // Second instance with a base near the top of memory to exercise wrap.
    rf_context_engine #(.BASE_ADDR(BASE_B), .AW(AW)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .busy(busy_b), .done(done_b), .rf_ra1(rf_ra1_b), .rf_rd1(rf_rd1_b),
        .rf_we(rf_we_b), .rf_wa(rf_wa_b), .rf_wd(rf_wd_b),
        .r30_out(r30_out_b), .r30_valid(r30_valid_b),
        .mem_req(mem_req_b), .mem_wr(mem_wr_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int rst_at, output bit aborted);
        int cyc, done_cnt, done_cyc, wr_cnt, rfwe_cnt, r30_cnt;
        int v_busy, v_dir, v_stab, v_ord, v_wrap, v_data, rf_bad, mem_bad;
        int next_idx, gwait, rv_cnt, rvd_now;
        logic [31:0]   rv_data, r30_val;
        logic [AW-1:0] h_addr;
        logic [31:0]   h_wd;
        logic [31:0]   exp_rf[32];
        bit hold, finished, abort_pending;

        aborted = 1'b0; finished = 1'b0; abort_pending = 1'b0; hold = 1'b0;
        done_cnt = 0; done_cyc = -1; wr_cnt = 0; rfwe_cnt = 0; r30_cnt = 0;
        v_busy = 0; v_dir = 0; v_stab = 0; v_ord = 0; v_wrap = 0; v_data = 0;
        next_idx = 1; rv_cnt = 0; rv_data = 0; r30_val = 0; h_addr = 0; h_wd = 0;
        gwait = (v.gmax > 0) ? $urandom_range(0, v.gmax) : 0;
        for (int n = 0; n < 32; n++) begin
            exp_rf[n] = (n == 0 || n == 30) ? rf_m[n] : mem_m[(BASE_A + n) % 1024];
            b_slot[n] = '1;
        end

        @(negedge clk); start = 1'b1; mode = v.mode;
        @(posedge clk); #1; start = 1'b0;
        cyc = 1;
        for (int k = 0; k < 4000 && !finished; k++) begin
            @(negedge clk);
            start = (v.poke && cyc == 20);
            if (v.poke && cyc == 20) mode = ~v.mode;

            mem_rvalid = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin mem_rvalid = 1'b1; mem_rdata = rv_data; end
            end else if ($urandom_range(0, 3) == 0) begin
                mem_rvalid = 1'b1; mem_rdata = $urandom;
            end

            if (!busy_a) v_busy++;
            if (v.mode == 1'b0 && rf_we_a) v_dir++;
            if (v.mode == 1'b1 && mem_req_a && mem_wr_a) v_dir++;
            if (hold && (!mem_req_a || mem_addr_a !== h_addr ||
                         (mem_wr_a && mem_wdata_a !== h_wd))) v_stab++;
            if (rf_we_a) begin
                rfwe_cnt++;
                if (rf_wa_a == 5'd0 || rf_wa_a == 5'd30 ||
                    rf_wd_a !== mem_m[(BASE_A + int'(rf_wa_a)) % 1024]) v_data++;
                rf_m[rf_wa_a] = rf_wd_a;
            end
            if (r30_valid_a) begin r30_cnt++; r30_val = r30_out_a; end
            if (done_a) begin done_cnt++; done_cyc = cyc; finished = 1'b1; end

            if (mem_req_a) begin
                if (gwait > 0) begin
                    mem_gnt = 1'b0; gwait--; hold = 1'b1;
                    h_addr = mem_addr_a; h_wd = mem_wdata_a;
                end else begin
                    mem_gnt = 1'b1; hold = 1'b0;
                    if (mem_addr_a !== AW'(BASE_A + next_idx)) v_ord++;
                    if (!mem_req_b || mem_addr_b !== AW'(BASE_B + next_idx)) v_wrap++;
                    if (next_idx < 32) b_slot[next_idx] = mem_addr_b;
                    if (mem_wr_a) begin
                        wr_cnt++;
                        if (next_idx > 31 || mem_wdata_a !== rf_m[next_idx]) v_data++;
                        mem_m[mem_addr_a] = mem_wdata_a;
                    end else begin
                        rvd_now = (v.rvd > 0) ? v.rvd : $urandom_range(1, 4);
                        rv_cnt  = rvd_now;
                        rv_data = mem_m[mem_addr_a];
                        if (next_idx == rst_at) abort_pending = 1'b1;
                    end
                    next_idx++;
                    gwait = (v.gmax > 0) ? $urandom_range(0, v.gmax) : 0;
                end
            end else begin
                mem_gnt = 1'($urandom_range(0, 1));
                hold = 1'b0;
            end

            @(posedge clk);
            cyc++;
            if (abort_pending) begin
                #2 rst_n = 1'b0;
                #1;
                chk("async_reset_outputs",
                    {63'd0, |{busy_a, done_a, rf_we_a, r30_valid_a, mem_req_a, mem_wr_a,
                              rf_ra1_a, rf_wa_a, rf_wd_a, r30_out_a, mem_addr_a, mem_wdata_a}},
                    64'd0);
                aborted = 1'b1;
                finished = 1'b1;
            end
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0; start = 1'b0;
        if (!finished) chk("op_timeout", 64'd1, 64'd0);
        if (aborted || !finished) return;

        @(negedge clk);
        chk("busy_after_fin", {63'd0, busy_a}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done_a) done_cnt++;
        end
        chk("done_pulses", done_cnt, 1);
        if (v.exp_done > 0) chk("done_cycle", done_cyc, v.exp_done);
        chk("busy_gaps", v_busy, 0);
        chk("direction_viol", v_dir, 0);
        chk("req_stability", v_stab, 0);
        chk("addr_order", v_ord, 0);
        chk("wrap_addr", v_wrap, 0);
        chk("data_viol", v_data, 0);
        chk("b_slot_r4", b_slot[4], 0);
        chk("b_slot_r31", b_slot[31], 27);
        if (v.mode == 1'b0) begin
            mem_bad = 0;
            for (int n = 1; n < 32; n++) if (mem_m[BASE_A + n] !== rf_m[n]) mem_bad++;
            chk("save_writes", wr_cnt, 31);
            chk("save_image", mem_bad, 0);
            chk("slot0_untouched", mem_m[BASE_A], 32'hC0FF_EE00);
        end else begin
            rf_bad = 0;
            for (int n = 0; n < 32; n++) if (rf_m[n] !== exp_rf[n]) rf_bad++;
            chk("restore_rf_writes", rfwe_cnt, 30);
            chk("restore_rf_image", rf_bad, 0);
            chk("r30_pulses", r30_cnt, 1);
            chk("r30_value", r30_val, mem_m[BASE_A + 30]);
        end
    endtask

    initial begin
        vec_t tbl[6];
        vec_t v;
        bit ab;

        tbl[0] = '{mode:1'b0, gmax:0, rvd:1, poke:1'b0, pat:0, exp_done:63};
        tbl[1] = '{mode:1'b1, gmax:0, rvd:3, poke:1'b0, pat:0, exp_done:156};
        tbl[2] = '{mode:1'b1, gmax:0, rvd:1, poke:1'b0, pat:1, exp_done:94};
        tbl[3] = '{mode:1'b0, gmax:5, rvd:1, poke:1'b0, pat:1, exp_done:-1};
        tbl[4] = '{mode:1'b0, gmax:0, rvd:1, poke:1'b1, pat:1, exp_done:63};
        tbl[5] = '{mode:1'b1, gmax:3, rvd:0, poke:1'b0, pat:1, exp_done:-1};

        for (int i = 0; i < 1024; i++) mem_m[i] = $urandom;
        mem_m[BASE_A] = 32'hC0FF_EE00;
        for (int i = 0; i < 32; i++) rf_m[i] = 32'hDEAD_0000 + i;

        #1;
        chk("rst_busy", {63'd0, busy_a}, 0);
        chk("rst_done", {63'd0, done_a}, 0);
        chk("rst_rf_we", {63'd0, rf_we_a}, 0);
        chk("rst_r30_valid", {63'd0, r30_valid_a}, 0);
        chk("rst_mem_req", {63'd0, mem_req_a}, 0);
        chk("rst_mem_wr", {63'd0, mem_wr_a}, 0);
        chk("rst_rf_ra1", rf_ra1_a, 0);
        chk("rst_rf_wa", rf_wa_a, 0);
        chk("rst_rf_wd", rf_wd_a, 0);
        chk("rst_r30_out", r30_out_a, 0);
        chk("rst_mem_addr", mem_addr_a, 0);
        chk("rst_mem_wdata", mem_wdata_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 6; t++) begin
            v = tbl[t];
            if (v.mode == 1'b0) begin
                for (int n = 0; n < 32; n++)
                    rf_m[n] = (v.pat == 0) ? 32'hA000_0000 + n : $urandom;
            end else begin
                for (int n = 0; n < 32; n++) begin
                    rf_m[n] = 32'hDEAD_0000 + n;
                    if (n != 0)
                        mem_m[BASE_A + n] = (v.pat == 0) ? 32'h5A5A_0000 + n : $urandom;
                end
            end
            run_op(v, 0, ab);
            if (t == 1) chk("r30_out_pattern", r30_out_a, 32'h5A5A_001E);
        end

        // Reset while waiting for read data of register 12.
        v = '{mode:1'b1, gmax:0, rvd:3, poke:1'b0, pat:1, exp_done:-1};
        run_op(v, 12, ab);
        chk("reset_abort_hit", {63'd0, ab}, 1);
        repeat (2) @(negedge clk);
        chk("quiet_in_reset", {63'd0, rf_we_a | mem_req_a | busy_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 32; n++) rf_m[n] = $urandom;
        v = '{mode:1'b0, gmax:2, rvd:1, poke:1'b0, pat:1, exp_done:-1};
        run_op(v, 0, ab);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/rf_context_engine.md
Name: rf_context_engine

Overview:
- Multicycle sequencer that drives the opposite side of the 32x32 register file's ports: read ports for saves, write port for restores.
- Save mode: copies registers 1..31 out to a word-addressed memory context area.
- Restore mode: reads the context area back and rewrites the registers.
- Sits between the register file and the data-memory arbiter; used for trap entry/exit and context switches.

Parameters:
BASE_ADDR, 0, word address of context slot 0; register n lives at BASE_ADDR+n
AW, 10, memory address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  command strobe; sampled only in IDLE
mode  in  1  0 = save (RF->mem), 1 = restore (mem->RF)
busy  out  1  high from the cycle after accepted start until the FIN cycle inclusive
done  out  1  one-cycle pulse in FIN
rf_ra1  out  5  register-file read address
rf_rd1  in  32  register-file read data (combinational from rf_ra1)
rf_we  out  1  register-file write enable
rf_wa  out  5  register-file write address
rf_wd  out  32  register-file write data
r30_out  out  32  restored r30 value
r30_valid  out  1  one-cycle pulse qualifying r30_out
mem_req  out  1  memory request
mem_wr  out  1  1 = write, 0 = read; valid with mem_req
mem_addr  out  AW  word address
mem_wdata  out  32  write data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data

Behaviour:
- Reset (async, rst_n=0): state IDLE, idx=1.
  - Outputs at reset: busy, done, rf_we, r30_valid, mem_req, mem_wr = 0; rf_ra1, rf_wa = 0; rf_wd, r30_out, mem_addr, mem_wdata = 0.
  - A reset mid-operation abandons the sequence with no further rf or mem activity; partial copies are not undone.
- States: IDLE, S_RD, S_REQ, R_REQ, R_WAIT, R_WR, FIN. idx is a 5-bit counter, 1..31.
- IDLE:
  - start=1 -> idx=1; next state S_RD if mode=0, R_REQ if mode=1.
  - start=0 -> stay in IDLE.
- S_RD: rf_ra1=idx; latch rf_rd1 into the mem_wdata register; -> S_REQ.
- S_REQ:
  - mem_req=1, mem_wr=1, mem_addr=BASE_ADDR+idx; address and data held stable until mem_gnt.
  - On mem_gnt: if idx==31 -> FIN, else idx+1 -> S_RD.
- R_REQ:
  - mem_req=1, mem_wr=0, mem_addr=BASE_ADDR+idx; held until mem_gnt.
  - On mem_gnt -> R_WAIT. Only one read is ever outstanding.
- R_WAIT:
  - Wait for mem_rvalid (earliest the cycle after gnt; unbounded wait, no timeout).
  - On mem_rvalid, mem_rdata is captured into rf_wd, or into r30_out when idx==30; -> R_WR.
- R_WR:
  - idx!=30: rf_we=1, rf_wa=idx for exactly one cycle.
  - idx==30: rf_we=0 and r30_valid=1 for one cycle instead. Register 30 is loaded via the register file's dedicated r30 input, so the engine never writes wa=30.
  - Then: if idx==31 -> FIN, else idx+1 -> R_REQ.
- FIN: done=1, busy=1 for one cycle; -> IDLE (busy=0 next cycle).
- Register 0 is never read, written, or stored; its slot at BASE_ADDR+0 is untouched.
- Address arithmetic: BASE_ADDR+idx truncated to AW bits (wraps modulo 2^AW).
- start while busy is ignored and not queued. mode is sampled only with an accepted start.
- mem_rvalid outside R_WAIT is ignored. mem_gnt is ignored when mem_req=0.
- rf_we is never asserted in save mode; mem_wr is never asserted in restore mode.
- Throughput with gnt always high and rvalid the cycle after gnt:
  - save: 2 cycles/register, 62 cycles + FIN;
  - restore: 3 cycles/register, 93 cycles + FIN.

Test Plan:
- Save, gnt tied high, BASE_ADDR=0x100, RF[n]=0xA000_0000+n -> 31 writes at 0x101..0x11F with matching data, no write to 0x100, done pulses exactly once at cycle 63 after start, busy=1 throughout.
- Restore, memory preloaded with [0x100+n]=0x5A5A_0000+n, rvalid 3 cycles after gnt -> 30 rf writes (1..29, 31) with correct data, no rf_we with wa=30 or wa=0, r30_valid single pulse with r30_out=0x5A5A_001E.
- Save with mem_gnt randomly withheld (up to 5 cycles) -> mem_addr and mem_wdata stable while mem_req=1 and gnt=0; final memory image matches RF.
- start pulsed again mid-save with mode=1 -> ignored; sequence completes as a save, single done pulse.
- rst_n asserted while in R_WAIT at idx=12 -> all outputs 0 immediately (async), no further rf_we; a new save after release starts at idx=1.
- BASE_ADDR=1020, AW=10 -> addresses wrap: register 4 stored at 0, register 31 at 27.
